// File: rtl/key_event_filter_pkg.sv
// Shared types and sizing helpers for the key_event_filter block.
// Optional auto-repeat is enabled with the KEY_REPEAT_EN macro.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    HELD,
    REL_FILT
  } chan_state_e;

  localparam int unsigned KEY_W_DEF        = 4;
  localparam int unsigned DEBOUNCE_CYC_DEF = 1_000_000;
  localparam int unsigned LONG_CYC_DEF     = 50_000_000;
  localparam int unsigned REPEAT_CYC_DEF   = 10_000_000;

  // Bits needed for a counter that runs 0..n-1
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_event_filter_if.sv
// Key pin and key event bus between board pins, the filter and its consumer.
// key_repeat is only active when the filter is built with KEY_REPEAT_EN.
interface key_event_filter_if #(
  parameter int unsigned KEY_W = key_pkg::KEY_W_DEF
);
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_level;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_release;
  logic [KEY_W-1:0] key_long;
  logic [KEY_W-1:0] key_repeat;

  modport master (
    output key_in,
    input  key_level, key_press, key_release, key_long, key_repeat
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, key_long, key_repeat
  );
endinterface

// File: rtl/key_event_filter_chan.sv
// One key channel: 2-flop synchroniser, press/release debounce FSM, hold timer.
// Auto-repeat counter is built only when KEY_REPEAT_EN is defined.
module key_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC   = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned FW = cnt_w(DEBOUNCE_CYC);
  localparam int unsigned HW = cnt_w(LONG_CYC);

  if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC || REPEAT_CYC < 2) begin : g_param_err
    $error("key_chan: illegal cycle parameters");
  end

  logic [1:0]    sync_q;
  logic          s;
  chan_state_e   state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  assign s = sync_q[1];

`ifdef KEY_REPEAT_EN
  localparam int unsigned RW = cnt_w(REPEAT_CYC);
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_act_q, rep_act_d;
  logic          repeat_q, repeat_d;
`endif

  // Next-state and event decode
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_FILT;
          fcnt_d  = '0;
        end
      end
      PRESS_FILT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (fcnt_q == FW'(DEBOUNCE_CYC - 1)) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      HELD: begin
        // Saturating hold timer; the single step into saturation is the long event
        if (hcnt_q != HW'(LONG_CYC - 1)) begin
          hcnt_d = hcnt_q + HW'(1);
          long_d = (hcnt_q == HW'(LONG_CYC - 2));
        end
        if (!s) begin
          state_d = REL_FILT;
          fcnt_d  = '0;
        end
      end
      REL_FILT: begin
        if (s) begin
          state_d = HELD;
        end else if (fcnt_q == FW'(DEBOUNCE_CYC - 1)) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef KEY_REPEAT_EN
    rcnt_d    = rcnt_q;
    rep_act_d = rep_act_q;
    repeat_d  = 1'b0;
    if (long_d) begin
      rep_act_d = 1'b1;
      rcnt_d    = '0;
    end else if (rep_act_q) begin
      if (state_d == IDLE) begin
        rep_act_d = 1'b0;
      end else if (rcnt_q == RW'(REPEAT_CYC - 1)) begin
        rcnt_d   = '0;
        repeat_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      state_q   <= IDLE;
      fcnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q    <= '0;
      rep_act_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      rcnt_q    <= rcnt_d;
      rep_act_q <= rep_act_d;
      repeat_q  <= repeat_d;
    end
  end
  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_event_filter.sv
// Multi-channel key debouncer: polarity normalisation plus one key_chan per pin.
// Define KEY_REPEAT_EN to build the auto-repeat pulse generators.
module key_event_filter
  import key_pkg::*;
#(
  parameter int unsigned KEY_W        = KEY_W_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC   = REPEAT_CYC_DEF,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  key_event_filter_if.slave  bus
);

  logic [KEY_W-1:0] key_n;

  // After this point 1 always means pressed
  assign key_n = ACTIVE_LOW ? ~bus.key_in : bus.key_in;

  for (genvar g = 0; g < int'(KEY_W); g++) begin : g_chan
    key_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_i     (key_n[g]),
      .level_o   (bus.key_level[g]),
      .press_o   (bus.key_press[g]),
      .release_o (bus.key_release[g]),
      .long_o    (bus.key_long[g]),
      .repeat_o  (bus.key_repeat[g])
    );
  end

endmodule
